// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO read port into a framed valid/ready stream
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_read,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [15:0]      pkt_count
);
    localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [1:0]       occ;
    logic             inflight;
    logic [BW-1:0]    beat;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop;
    logic [1:0]       rem;

    assign m_valid = occ != 2'd0;
    assign m_data  = slot0;
    assign m_last  = m_valid && beat == LAST_BEAT;
    assign pop     = m_valid && m_ready;
    assign rem     = occ - {1'b0, pop};
    // a read is only issued when the word it returns is guaranteed a free slot two cycles later
    assign fifo_read = rst && enable && !fifo_empty &&
                       ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});

    // buffer shifts on pop; a returning word lands in the first slot left free after the shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            beat      <= '0;
            slot0     <= '0;
            slot1     <= '0;
            pkt_count <= 16'd0;
        end else begin
            inflight <= fifo_read;
            occ      <= rem + {1'b0, inflight};
            slot0    <= (inflight && rem == 2'd0) ? fifo_dout : (pop ? slot1 : slot0);
            slot1    <= (inflight && rem == 2'd1) ? fifo_dout : slot1;
            if (pop) begin
                beat      <= m_last ? '0 : beat + 1'b1;
                pkt_count <= pkt_count + {15'd0, m_last};
            end
        end
    end
endmodule
